// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for pipe_stage_elastic: upstream push side, downstream pop side,
// flush control and the occupancy level.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: a two-entry skid stage (registered in_ready) when SKID=1,
// or a single-entry stage with combinational in_ready when SKID=0.
module pipe_stage_elastic #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = 1
) (
    input logic                  clk,
    input logic                  rst,
    pipe_stage_elastic_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             push;
    logic             pop;

    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.level     = 2'(state);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // The main register is reloaded with RESET_VAL whenever the stage empties,
    // so out_data reads RESET_VAL in EMPTY without an output mux.
    always_comb begin
        state_next = state;
        main_d     = main_q;
        skid_d     = skid_q;
        if (bus.flush) begin
            state_next = EMPTY;
            main_d     = RESET_VAL;
            skid_d     = RESET_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_d     = bus.in_data;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (push && SKID != 0) begin
                        skid_d     = bus.in_data;
                        state_next = TWO;
                    end else if (pop) begin
                        main_d     = RESET_VAL;
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_d     = skid_q;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_d     = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
        end else begin
            state  <= state_next;
            main_q <= main_d;
        end
    end

    // Only the skid variant owns a second register; its in_ready never looks at out_ready.
    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= RESET_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
            assign bus.in_ready = (state != TWO);
        end else begin : g_noskid
            assign skid_q       = RESET_VAL;
            assign bus.in_ready = (state == EMPTY) | bus.out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: six configurations (SKID 0/1, WIDTH 32/1/64), each with a
// queue-based reference model, plus directed literal checks on the WIDTH=32 instances.
module tb_pipe_stage_elastic;

    localparam int          N    = 6;
    localparam logic [63:0] RV64 = 64'h0123_4567_DEAD_BEEF;
    localparam logic [63:0] RV0  = 64'h0000_0000_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]        flush_s;
    logic [N-1:0]        in_valid_s;
    logic [N-1:0]        out_ready_s;
    logic [N-1:0][63:0]  in_data_s;

    logic [N-1:0]        dut_in_ready;
    logic [N-1:0]        dut_out_valid;
    logic [N-1:0][63:0]  dut_out_data;
    logic [N-1:0][1:0]   dut_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Index 0/1 are the WIDTH=32 directed instances; 2..5 cover WIDTH 1 and 64.
    for (genvar k = 0; k < N; k++) begin : g
        localparam int          SK   = (k % 2 == 0) ? 1 : 0;
        localparam int          W    = (k < 2) ? 32 : ((k < 4) ? 1 : 64);
        localparam int          MAXL = (SK != 0) ? 2 : 1;
        localparam logic [W-1:0] RV  = RV64[W-1:0];
        localparam logic [63:0] MASK = (W == 64) ? {64{1'b1}} : ((64'd1 << W) - 64'd1);

        pipe_stage_elastic_if #(.WIDTH(W)) bus ();

        pipe_stage_elastic #(
            .WIDTH     (W),
            .RESET_VAL (RV),
            .SKID      (SK)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.flush        = flush_s[k];
        assign bus.in_valid     = in_valid_s[k];
        assign bus.in_data      = in_data_s[k][W-1:0];
        assign bus.out_ready    = out_ready_s[k];
        assign dut_in_ready[k]  = bus.in_ready;
        assign dut_out_valid[k] = bus.out_valid;
        assign dut_out_data[k]  = 64'(bus.out_data);
        assign dut_level[k]     = bus.level;

        logic [63:0] q[$];

        initial begin : model
            logic rdy;
            logic push;
            logic pop;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    q.delete();
                end else begin
                    rdy  = (SK != 0) ? (q.size() < 2) : (q.size() == 0 || out_ready_s[k]);
                    push = in_valid_s[k] & rdy;
                    pop  = (q.size() != 0) & out_ready_s[k];
                    if (flush_s[k]) begin
                        q.delete();
                    end else begin
                        if (pop) void'(q.pop_front());
                        if (push) q.push_back(in_data_s[k] & MASK);
                    end
                end
            end
        end

        initial begin : compare
            int          exp_lvl;
            logic        exp_rdy;
            logic [63:0] exp_data;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    exp_lvl  = q.size();
                    exp_rdy  = (SK != 0) ? (q.size() < 2) : (q.size() == 0 || out_ready_s[k]);
                    exp_data = (q.size() != 0) ? q[0] : 64'(RV);
                    check_output($sformatf("g%0d.level", k), 64'(dut_level[k]), 64'(exp_lvl));
                    check_output($sformatf("g%0d.out_valid", k), 64'(dut_out_valid[k]), 64'(exp_lvl != 0));
                    check_output($sformatf("g%0d.out_data", k), dut_out_data[k], exp_data);
                    check_output($sformatf("g%0d.in_ready", k), 64'(dut_in_ready[k]), 64'(exp_rdy));
                    check_output($sformatf("g%0d.level_bound", k), 64'(int'(dut_level[k]) <= MAXL), 64'd1);
                end
            end
        end
    end

    task automatic apply_stimulus(input int k, input logic fl, input logic vld,
                                  input logic [63:0] data, input logic rdy);
        flush_s[k]     = fl;
        in_valid_s[k]  = vld;
        in_data_s[k]   = data;
        out_ready_s[k] = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input int k, input string tag, input logic [1:0] lvl,
                                input logic [63:0] data, input logic rdy);
        check_output({tag, ".level"}, 64'(dut_level[k]), 64'(lvl));
        check_output({tag, ".out_valid"}, 64'(dut_out_valid[k]), 64'(lvl != 2'd0));
        check_output({tag, ".out_data"}, dut_out_data[k], data);
        check_output({tag, ".in_ready"}, 64'(dut_in_ready[k]), 64'(rdy));
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < N; k++) apply_stimulus(k, 1'b0, 1'b0, 64'd0, 1'b0);
        #1 rst = 1'b1;
        #2;
        expect_state(0, "reset_s1", 2'd0, RV0, 1'b1);
        expect_state(1, "reset_s0", 2'd0, RV0, 1'b1);
        @(negedge clk);
        #1 rst = 1'b0;
        step();

        // Back-to-back streaming with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(0, 1'b0, 1'b1, 64'(i), 1'b1);
            step();
            expect_state(0, $sformatf("stream%0d", i), 2'd1, 64'(i), 1'b1);
        end
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(0, "stream_end", 2'd0, RV0, 1'b1);

        // Backpressure fills the skid register, then drains in order
        apply_stimulus(0, 1'b0, 1'b1, 64'hA, 1'b0);
        step();
        expect_state(0, "bp_a", 2'd1, 64'hA, 1'b1);
        apply_stimulus(0, 1'b0, 1'b1, 64'hB, 1'b0);
        step();
        expect_state(0, "bp_full", 2'd2, 64'hA, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b0);
        step();
        expect_state(0, "bp_hold", 2'd2, 64'hA, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(0, "bp_pop1", 2'd1, 64'hB, 1'b1);
        step();
        expect_state(0, "bp_pop2", 2'd0, RV0, 1'b1);

        // Flush from TWO with a simultaneous offer
        apply_stimulus(0, 1'b0, 1'b1, 64'h11, 1'b0);
        step();
        apply_stimulus(0, 1'b0, 1'b1, 64'h22, 1'b0);
        step();
        expect_state(0, "fl_two", 2'd2, 64'h11, 1'b0);
        apply_stimulus(0, 1'b1, 1'b1, 64'h33, 1'b0);
        step();
        expect_state(0, "fl_done", 2'd0, RV0, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(0, "fl_quiet1", 2'd0, RV0, 1'b1);
        step();
        expect_state(0, "fl_quiet2", 2'd0, RV0, 1'b1);

        // Flush from ONE: the push is acknowledged but dropped
        apply_stimulus(0, 1'b0, 1'b1, 64'h44, 1'b0);
        step();
        apply_stimulus(0, 1'b1, 1'b1, 64'h55, 1'b0);
        #1 check_output("fl_ack.in_ready", 64'(dut_in_ready[0]), 64'd1);
        step();
        expect_state(0, "fl_one", 2'd0, RV0, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(0, "fl_one_after", 2'd0, RV0, 1'b1);

        // Asynchronous reset pulse between edges while full
        apply_stimulus(0, 1'b0, 1'b1, 64'h66, 1'b0);
        step();
        apply_stimulus(0, 1'b0, 1'b1, 64'h77, 1'b0);
        step();
        expect_state(0, "ar_pre", 2'd2, 64'h66, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b0);
        #2 rst = 1'b1;
        #1 expect_state(0, "ar_imm", 2'd0, RV0, 1'b1);
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 1'b1, 64'h55, 1'b0);
        step();
        expect_state(0, "ar_push", 2'd1, 64'h55, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(0, "ar_drain", 2'd0, RV0, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 64'd0, 1'b0);

        // Single-entry stage: in_ready follows ~out_valid | out_ready within the cycle
        apply_stimulus(1, 1'b0, 1'b1, 64'h100, 1'b1);
        #1 check_output("s0_rdy_empty", 64'(dut_in_ready[1]), 64'd1);
        step();
        expect_state(1, "s0_a", 2'd1, 64'h100, 1'b1);
        apply_stimulus(1, 1'b0, 1'b1, 64'h101, 1'b0);
        #1 check_output("s0_rdy_stall", 64'(dut_in_ready[1]), 64'd0);
        step();
        expect_state(1, "s0_hold", 2'd1, 64'h100, 1'b0);
        apply_stimulus(1, 1'b0, 1'b1, 64'h101, 1'b1);
        #1 check_output("s0_rdy_go", 64'(dut_in_ready[1]), 64'd1);
        step();
        expect_state(1, "s0_b", 2'd1, 64'h101, 1'b1);
        apply_stimulus(1, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        expect_state(1, "s0_empty", 2'd0, RV0, 1'b1);

        // Random traffic on every configuration, checked cycle by cycle against the models
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                apply_stimulus(k, ($urandom_range(15) == 0), ($urandom_range(1) == 1),
                               {$urandom, $urandom}, ($urandom_range(3) != 0));
            end
            step();
        end
        for (int k = 0; k < N; k++) apply_stimulus(k, 1'b1, 1'b0, 64'd0, 1'b0);
        step();
        for (int k = 0; k < N; k++) apply_stimulus(k, 1'b0, 1'b0, 64'd0, 1'b0);
        step();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
